// File: rtl/i2c_fifo_thr.sv
// i2c_fifo_thr: single-clock synchronous FIFO with programmable almost-full and
// almost-empty flags, synchronous flush and sticky overflow/underflow flags.
//
// Parameters:
//   DW    - data width (1..32)
//   DEPTH - number of entries, power of two (2..256)
//   FWFT  - 0: dout registered, loaded on an accepted read
//           1: dout shows the head entry combinationally (first-word-fall-through)
//
// Ports:
//   clk, rstn           - clock (rising edge), asynchronous active-low reset
//   flush               - synchronous clear of contents and sticky flags
//   wr, din             - write strobe and data
//   rd, dout            - read/pop strobe and read data
//   full, empty, usedw  - occupancy status
//   pfull_thr, pfull    - almost-full threshold (0 disables) and flag
//   pempty_thr, pempty  - almost-empty threshold and flag
//   err_clr, ovf, udf   - clear and sticky overflow / underflow flags
module i2c_fifo_thr #(
    parameter int unsigned DW    = 8,
    parameter int unsigned DEPTH = 16,
    parameter int unsigned FWFT  = 0,
    localparam int unsigned AW   = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          flush,
    input  logic          wr,
    input  logic [DW-1:0] din,
    input  logic          rd,
    output logic [DW-1:0] dout,
    output logic          full,
    output logic          empty,
    output logic [AW:0]   usedw,
    input  logic [AW:0]   pfull_thr,
    input  logic [AW:0]   pempty_thr,
    output logic          pfull,
    output logic          pempty,
    input  logic          err_clr,
    output logic          ovf,
    output logic          udf
);

    localparam logic [AW:0] CntFull = (AW+1)'(DEPTH);
    localparam logic [AW:0] CntOne  = (AW+1)'(1);

    logic [DW-1:0] mem_q [DEPTH];

    logic [AW:0] wr_ptr_q, wr_ptr_d;
    logic [AW:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0] usedw_q, usedw_d;
    logic        ovf_q, ovf_d;
    logic        udf_q, udf_d;

    logic wr_acc, rd_acc;
    logic ovf_set, udf_set;

    // Status decodes from the registered count only, so they cannot glitch.
    assign full   = (usedw_q == CntFull);
    assign empty  = (usedw_q == '0);
    assign usedw  = usedw_q;
    assign pfull  = (pfull_thr != '0) && (usedw_q >= pfull_thr);
    assign pempty = (usedw_q <= pempty_thr);
    assign ovf    = ovf_q;
    assign udf    = udf_q;

    always_comb begin
        // A read frees a slot in the same cycle, so a full FIFO still takes wr+rd.
        rd_acc  = rd & ~empty & ~flush;
        wr_acc  = wr & (~full | rd_acc) & ~flush;
        ovf_set = wr & full & ~rd_acc & ~flush;
        udf_set = rd & empty & ~flush;

        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        usedw_d  = usedw_q;
        ovf_d    = ovf_q;
        udf_d    = udf_q;

        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            usedw_d  = '0;
            ovf_d    = 1'b0;
            udf_d    = 1'b0;
        end else begin
            if (wr_acc) begin
                wr_ptr_d = wr_ptr_q + CntOne;
            end
            if (rd_acc) begin
                rd_ptr_d = rd_ptr_q + CntOne;
            end
            case ({wr_acc, rd_acc})
                2'b10:   usedw_d = usedw_q + CntOne;
                2'b01:   usedw_d = usedw_q - CntOne;
                default: usedw_d = usedw_q;
            endcase
            // A new error in the same cycle as err_clr wins.
            ovf_d = ovf_set | (ovf_q & ~err_clr);
            udf_d = udf_set | (udf_q & ~err_clr);
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            usedw_q  <= '0;
            ovf_q    <= 1'b0;
            udf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            usedw_q  <= usedw_d;
            ovf_q    <= ovf_d;
            udf_q    <= udf_d;
        end
    end

    // Storage has no reset; only the pointers define validity.
    always_ff @(posedge clk) begin
        if (wr_acc) begin
            mem_q[wr_ptr_q[AW-1:0]] <= din;
        end
    end

    if (FWFT != 0) begin : g_fwft
        // Forced to zero while empty so dout reads 0 after reset despite unreset storage.
        assign dout = empty ? '0 : mem_q[rd_ptr_q[AW-1:0]];
    end else begin : g_reg
        logic [DW-1:0] dout_q;

        // Holds across flush; only an accepted read reloads it.
        always_ff @(posedge clk or negedge rstn) begin
            if (!rstn) begin
                dout_q <= '0;
            end else if (rd_acc) begin
                dout_q <= mem_q[rd_ptr_q[AW-1:0]];
            end
        end

        assign dout = dout_q;
    end

endmodule

// File: tb/tb_i2c_fifo_thr.sv
module tb_i2c_fifo_thr;

    logic clk = 1'b0;
    logic rstn = 1'b1;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Group A: DW=8, DEPTH=16, registered (a0) and FWFT (a1) instances on shared inputs.
    logic       a_flush = 0, a_wr = 0, a_rd = 0, a_err_clr = 0;
    logic [7:0] a_din = '0;
    logic [4:0] a_pfull_thr = 5'd12, a_pempty_thr = 5'd3;
    logic [7:0] a0_dout, a1_dout;
    logic       a0_full, a0_empty, a0_pfull, a0_pempty, a0_ovf, a0_udf;
    logic       a1_full, a1_empty, a1_pfull, a1_pempty, a1_ovf, a1_udf;
    logic [4:0] a0_usedw, a1_usedw;

    // Group B: DW=10, DEPTH=4, registered (b0) and FWFT (b1) instances on shared inputs.
    logic       b_flush = 0, b_wr = 0, b_rd = 0, b_err_clr = 0;
    logic [9:0] b_din = '0;
    logic [2:0] b_pfull_thr = '0, b_pempty_thr = '0;
    logic [9:0] b0_dout, b1_dout;
    logic       b0_full, b0_empty, b0_pfull, b0_pempty, b0_ovf, b0_udf;
    logic       b1_full, b1_empty, b1_pfull, b1_pempty, b1_ovf, b1_udf;
    logic [2:0] b0_usedw, b1_usedw;

    i2c_fifo_thr #(.DW(8), .DEPTH(16), .FWFT(0)) u_a0 (
        .clk(clk), .rstn(rstn), .flush(a_flush), .wr(a_wr), .din(a_din), .rd(a_rd),
        .dout(a0_dout), .full(a0_full), .empty(a0_empty), .usedw(a0_usedw),
        .pfull_thr(a_pfull_thr), .pempty_thr(a_pempty_thr), .pfull(a0_pfull),
        .pempty(a0_pempty), .err_clr(a_err_clr), .ovf(a0_ovf), .udf(a0_udf)
    );
    i2c_fifo_thr #(.DW(8), .DEPTH(16), .FWFT(1)) u_a1 (
        .clk(clk), .rstn(rstn), .flush(a_flush), .wr(a_wr), .din(a_din), .rd(a_rd),
        .dout(a1_dout), .full(a1_full), .empty(a1_empty), .usedw(a1_usedw),
        .pfull_thr(a_pfull_thr), .pempty_thr(a_pempty_thr), .pfull(a1_pfull),
        .pempty(a1_pempty), .err_clr(a_err_clr), .ovf(a1_ovf), .udf(a1_udf)
    );
    i2c_fifo_thr #(.DW(10), .DEPTH(4), .FWFT(0)) u_b0 (
        .clk(clk), .rstn(rstn), .flush(b_flush), .wr(b_wr), .din(b_din), .rd(b_rd),
        .dout(b0_dout), .full(b0_full), .empty(b0_empty), .usedw(b0_usedw),
        .pfull_thr(b_pfull_thr), .pempty_thr(b_pempty_thr), .pfull(b0_pfull),
        .pempty(b0_pempty), .err_clr(b_err_clr), .ovf(b0_ovf), .udf(b0_udf)
    );
    i2c_fifo_thr #(.DW(10), .DEPTH(4), .FWFT(1)) u_b1 (
        .clk(clk), .rstn(rstn), .flush(b_flush), .wr(b_wr), .din(b_din), .rd(b_rd),
        .dout(b1_dout), .full(b1_full), .empty(b1_empty), .usedw(b1_usedw),
        .pfull_thr(b_pfull_thr), .pempty_thr(b_pempty_thr), .pfull(b1_pfull),
        .pempty(b1_pempty), .err_clr(b_err_clr), .ovf(b1_ovf), .udf(b1_udf)
    );

    // Advance one clock and settle just after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        #1 rstn = 1'b0;
        step();
        step();
        n_checks++; if (a0_usedw !== 5'd0) begin n_fail++; $display("FAIL reset_usedw: got %0d want 0", a0_usedw); end
        n_checks++; if (a0_empty !== 1'b1) begin n_fail++; $display("FAIL reset_empty: got %b want 1", a0_empty); end
        n_checks++; if (a0_full !== 1'b0) begin n_fail++; $display("FAIL reset_full: got %b want 0", a0_full); end
        n_checks++; if ({a0_ovf, a0_udf} !== 2'b00) begin n_fail++; $display("FAIL reset_flags: got %b want 00", {a0_ovf, a0_udf}); end
        n_checks++; if (a0_dout !== 8'h00) begin n_fail++; $display("FAIL reset_dout_reg: got %h want 00", a0_dout); end
        n_checks++; if (a1_dout !== 8'h00) begin n_fail++; $display("FAIL reset_dout_fwft: got %h want 00", a1_dout); end
        n_checks++; if ({a0_pfull, a0_pempty} !== 2'b01) begin n_fail++; $display("FAIL reset_thr_flags: got %b want 01", {a0_pfull, a0_pempty}); end
        n_checks++; if (b1_dout !== 10'h000) begin n_fail++; $display("FAIL reset_dout_b1: got %h want 000", b1_dout); end
        rstn = 1'b1;
        step();
    endtask

    task automatic test_fill();
        for (int i = 1; i <= 16; i++) begin
            a_wr  = 1'b1;
            a_din = 8'(i);
            step();
            n_checks++; if (a0_usedw !== 5'(i)) begin n_fail++; $display("FAIL fill_usedw[%0d]: got %0d want %0d", i, a0_usedw, i); end
            n_checks++; if (a0_full !== (i == 16)) begin n_fail++; $display("FAIL fill_full[%0d]: got %b want %b", i, a0_full, i == 16); end
            n_checks++; if (a0_pfull !== (i >= 12)) begin n_fail++; $display("FAIL fill_pfull[%0d]: got %b want %b", i, a0_pfull, i >= 12); end
            n_checks++; if (a0_pempty !== (i <= 3)) begin n_fail++; $display("FAIL fill_pempty[%0d]: got %b want %b", i, a0_pempty, i <= 3); end
            n_checks++; if (a1_dout !== 8'h01) begin n_fail++; $display("FAIL fill_fwft_head[%0d]: got %h want 01", i, a1_dout); end
        end
        a_wr = 1'b0;
        a_pfull_thr = 5'd0;
        #1;
        n_checks++; if (a0_pfull !== 1'b0) begin n_fail++; $display("FAIL pfull_disabled: got %b want 0", a0_pfull); end
        a_pfull_thr = 5'd12;
        #1;
        n_checks++; if (a0_pfull !== 1'b1) begin n_fail++; $display("FAIL pfull_reenabled: got %b want 1", a0_pfull); end
    endtask

    task automatic test_overflow();
        a_wr  = 1'b1;
        a_din = 8'hAA;
        step();
        n_checks++; if (a0_ovf !== 1'b1) begin n_fail++; $display("FAIL ovf_set: got %b want 1", a0_ovf); end
        n_checks++; if (a0_usedw !== 5'd16) begin n_fail++; $display("FAIL ovf_usedw: got %0d want 16", a0_usedw); end
        a_din = 8'hBB;
        a_rd  = 1'b1;
        step();
        n_checks++; if (a0_usedw !== 5'd16) begin n_fail++; $display("FAIL full_wr_rd_usedw: got %0d want 16", a0_usedw); end
        n_checks++; if (a0_dout !== 8'h01) begin n_fail++; $display("FAIL full_wr_rd_dout: got %h want 01", a0_dout); end
        n_checks++; if (a1_dout !== 8'h02) begin n_fail++; $display("FAIL full_wr_rd_fwft: got %h want 02", a1_dout); end
        a_wr = 1'b0;
        a_rd = 1'b0;
        a_err_clr = 1'b1;
        step();
        a_err_clr = 1'b0;
        n_checks++; if (a0_ovf !== 1'b0) begin n_fail++; $display("FAIL err_clr_ovf: got %b want 0", a0_ovf); end
    endtask

    task automatic test_drain();
        logic [7:0] exp_q[$];
        logic [7:0] e;
        for (int i = 2; i <= 16; i++) exp_q.push_back(8'(i));
        exp_q.push_back(8'hBB);
        for (int i = 0; i < 16; i++) begin
            a_rd = 1'b1;
            step();
            e = exp_q.pop_front();
            n_checks++; if (a0_dout !== e) begin n_fail++; $display("FAIL drain_dout[%0d]: got %h want %h", i, a0_dout, e); end
            n_checks++; if (a0_usedw !== 5'(exp_q.size())) begin n_fail++; $display("FAIL drain_usedw[%0d]: got %0d want %0d", i, a0_usedw, exp_q.size()); end
            e = (exp_q.size() > 0) ? exp_q[0] : 8'h00;
            n_checks++; if (a1_dout !== e) begin n_fail++; $display("FAIL drain_fwft[%0d]: got %h want %h", i, a1_dout, e); end
        end
        a_rd = 1'b0;
        n_checks++; if (a0_empty !== 1'b1) begin n_fail++; $display("FAIL drain_empty: got %b want 1", a0_empty); end
        n_checks++; if ({a0_ovf, a0_udf} !== 2'b00) begin n_fail++; $display("FAIL drain_flags: got %b want 00", {a0_ovf, a0_udf}); end
    endtask

    task automatic test_underflow_fwft();
        a_wr  = 1'b1;
        a_rd  = 1'b1;
        a_din = 8'h5A;
        step();
        a_wr = 1'b0;
        a_rd = 1'b0;
        n_checks++; if (a1_udf !== 1'b1) begin n_fail++; $display("FAIL udf_set: got %b want 1", a1_udf); end
        n_checks++; if (a1_usedw !== 5'd1) begin n_fail++; $display("FAIL udf_usedw: got %0d want 1", a1_usedw); end
        n_checks++; if (a1_dout !== 8'h5A) begin n_fail++; $display("FAIL udf_fwft_dout: got %h want 5a", a1_dout); end
        n_checks++; if (a1_empty !== 1'b0) begin n_fail++; $display("FAIL udf_empty: got %b want 0", a1_empty); end
        n_checks++; if (a0_dout !== 8'hBB) begin n_fail++; $display("FAIL udf_dout_hold: got %h want bb", a0_dout); end
        a_rd = 1'b1;
        a_err_clr = 1'b1;
        step();
        a_rd = 1'b0;
        a_err_clr = 1'b0;
        n_checks++; if (a0_dout !== 8'h5A) begin n_fail++; $display("FAIL udf_pop_dout: got %h want 5a", a0_dout); end
        n_checks++; if (a0_udf !== 1'b0) begin n_fail++; $display("FAIL udf_clr: got %b want 0", a0_udf); end
    endtask

    task automatic test_flush();
        for (int i = 0; i < 7; i++) begin
            a_wr  = 1'b1;
            a_din = 8'($urandom);
            step();
        end
        n_checks++; if (a0_usedw !== 5'd7) begin n_fail++; $display("FAIL flush_pre_usedw: got %0d want 7", a0_usedw); end
        a_flush = 1'b1;
        a_rd    = 1'b1;
        step();
        a_flush = 1'b0;
        a_wr    = 1'b0;
        a_rd    = 1'b0;
        n_checks++; if (a0_usedw !== 5'd0) begin n_fail++; $display("FAIL flush_usedw: got %0d want 0", a0_usedw); end
        n_checks++; if (a0_empty !== 1'b1) begin n_fail++; $display("FAIL flush_empty: got %b want 1", a0_empty); end
        n_checks++; if ({a0_ovf, a0_udf} !== 2'b00) begin n_fail++; $display("FAIL flush_flags: got %b want 00", {a0_ovf, a0_udf}); end
        n_checks++; if (a0_dout !== 8'h5A) begin n_fail++; $display("FAIL flush_dout_hold: got %h want 5a", a0_dout); end
        a_wr  = 1'b1;
        a_din = 8'h33;
        step();
        a_wr = 1'b0;
        n_checks++; if (a1_dout !== 8'h33) begin n_fail++; $display("FAIL flush_fwft_33: got %h want 33", a1_dout); end
        a_rd = 1'b1;
        step();
        a_rd = 1'b0;
        n_checks++; if (a0_dout !== 8'h33) begin n_fail++; $display("FAIL flush_read_33: got %h want 33", a0_dout); end
        n_checks++; if (a0_empty !== 1'b1) begin n_fail++; $display("FAIL flush_final_empty: got %b want 1", a0_empty); end
    endtask

    task automatic test_random();
        logic [9:0] mq[$];
        logic [9:0] m_dout = '0;
        logic [9:0] head;
        logic       m_ovf = 1'b0, m_udf = 1'b0;
        logic       rd_ok, wr_ok, e_pfull, e_pempty;
        int         sz;
        for (int c = 0; c < 1000; c++) begin
            b_flush   = ($urandom_range(0, 19) == 0);
            b_wr      = ($urandom_range(0, 9) < 6);
            b_rd      = ($urandom_range(0, 9) < 5);
            b_err_clr = ($urandom_range(0, 15) == 0);
            b_din     = 10'($urandom);
            if ($urandom_range(0, 31) == 0) begin
                b_pfull_thr  = 3'($urandom);
                b_pempty_thr = 3'($urandom);
            end
            sz = mq.size();
            if (b_flush) begin
                mq.delete();
                m_ovf = 1'b0;
                m_udf = 1'b0;
            end else begin
                rd_ok = b_rd && (sz > 0);
                wr_ok = b_wr && ((sz < 4) || rd_ok);
                if (rd_ok) m_dout = mq.pop_front();
                if (wr_ok) mq.push_back(b_din);
                if (b_wr && !wr_ok) m_ovf = 1'b1;
                else if (b_err_clr) m_ovf = 1'b0;
                if (b_rd && (sz == 0)) m_udf = 1'b1;
                else if (b_err_clr) m_udf = 1'b0;
            end
            step();
            sz       = mq.size();
            head     = (sz > 0) ? mq[0] : 10'h000;
            e_pfull  = (b_pfull_thr != 0) && (sz >= int'(b_pfull_thr));
            e_pempty = (sz <= int'(b_pempty_thr));
            n_checks++; if (b0_usedw !== 3'(sz)) begin n_fail++; $display("FAIL rnd_usedw@%0d: got %0d want %0d", c, b0_usedw, sz); end
            n_checks++; if (b0_empty !== (sz == 0)) begin n_fail++; $display("FAIL rnd_empty@%0d: got %b want %b", c, b0_empty, sz == 0); end
            n_checks++; if (b0_full !== (sz == 4)) begin n_fail++; $display("FAIL rnd_full@%0d: got %b want %b", c, b0_full, sz == 4); end
            n_checks++; if (b0_ovf !== m_ovf) begin n_fail++; $display("FAIL rnd_ovf@%0d: got %b want %b", c, b0_ovf, m_ovf); end
            n_checks++; if (b0_udf !== m_udf) begin n_fail++; $display("FAIL rnd_udf@%0d: got %b want %b", c, b0_udf, m_udf); end
            n_checks++; if (b0_pfull !== e_pfull) begin n_fail++; $display("FAIL rnd_pfull@%0d: got %b want %b", c, b0_pfull, e_pfull); end
            n_checks++; if (b0_pempty !== e_pempty) begin n_fail++; $display("FAIL rnd_pempty@%0d: got %b want %b", c, b0_pempty, e_pempty); end
            n_checks++; if (b0_dout !== m_dout) begin n_fail++; $display("FAIL rnd_dout_reg@%0d: got %h want %h", c, b0_dout, m_dout); end
            n_checks++; if (b1_dout !== head) begin n_fail++; $display("FAIL rnd_dout_fwft@%0d: got %h want %h", c, b1_dout, head); end
            n_checks++; if (b1_usedw !== 3'(sz)) begin n_fail++; $display("FAIL rnd_usedw_fwft@%0d: got %0d want %0d", c, b1_usedw, sz); end
        end
        b_flush = 1'b0;
        b_rd = 1'b0;
        b_err_clr = 1'b0;
    endtask

    task automatic test_reset_midstream();
        b_pfull_thr  = 3'd3;
        b_pempty_thr = 3'd1;
        for (int i = 0; i < 6; i++) begin
            b_wr  = 1'b1;
            b_rd  = (i == 2);
            b_din = 10'($urandom);
            step();
        end
        b_rd = 1'b0;
        n_checks++; if ({b0_full, b0_ovf, b0_pfull} !== 3'b111) begin n_fail++; $display("FAIL mid_pre_state: got %b want 111", {b0_full, b0_ovf, b0_pfull}); end
        rstn = 1'b0;
        #1;
        n_checks++; if (b0_usedw !== 3'd0) begin n_fail++; $display("FAIL mid_rst_usedw: got %0d want 0", b0_usedw); end
        n_checks++; if ({b0_empty, b0_full} !== 2'b10) begin n_fail++; $display("FAIL mid_rst_empty_full: got %b want 10", {b0_empty, b0_full}); end
        n_checks++; if ({b0_ovf, b0_udf} !== 2'b00) begin n_fail++; $display("FAIL mid_rst_flags: got %b want 00", {b0_ovf, b0_udf}); end
        n_checks++; if ({b0_pfull, b0_pempty} !== 2'b01) begin n_fail++; $display("FAIL mid_rst_thr: got %b want 01", {b0_pfull, b0_pempty}); end
        n_checks++; if (b0_dout !== 10'h000) begin n_fail++; $display("FAIL mid_rst_dout_reg: got %h want 000", b0_dout); end
        n_checks++; if (b1_dout !== 10'h000) begin n_fail++; $display("FAIL mid_rst_dout_fwft: got %h want 000", b1_dout); end
        b_wr = 1'b0;
        step();
        rstn = 1'b1;
        step();
    endtask

    initial begin
        test_reset();
        test_fill();
        test_overflow();
        test_drain();
        test_underflow_fwft();
        test_flush();
        test_random();
        test_reset_midstream();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/i2c_fifo_thr.md
# i2c_fifo_thr

Parametrised successor to the fixed-depth TX/RX FIFOs inside the I2C core. It is a single-clock synchronous FIFO with configurable width, depth and read mode (standard or first-word-fall-through). It adds features the current FIFOs lack:
- internal programmable almost-full and almost-empty threshold flags, replacing external comparison against `pirq`;
- synchronous flush;
- sticky overflow and underflow error flags.

It replaces both `u_tx_fifo` (DW=10) and `u_rx_fifo` (DW=8) in the core and drives the `irq_req` and `sr` bits directly.

## Interface
Parameters:
- `DW`, 8, data width in bits (1..32)
- `DEPTH`, 16, number of entries; power of two, 2..256
- `FWFT`, 0, 0 = registered read (data one cycle after `rd`), 1 = first-word-fall-through
- `AW` (localparam), $clog2(DEPTH), address width; count width is AW+1

Ports:
- `clk`  in  1  clock; all logic on rising edge
- `rstn`  in  1  asynchronous active-low reset
- `flush`  in  1  synchronous clear of contents and sticky flags
- `wr`  in  1  write strobe
- `din`  in  DW  write data
- `rd`  in  1  read/pop strobe
- `dout`  out  DW  read data
- `full`  out  1  usedw == DEPTH
- `empty`  out  1  usedw == 0
- `usedw`  out  AW+1  occupancy, 0..DEPTH
- `pfull_thr`  in  AW+1  almost-full threshold; 0 disables
- `pempty_thr`  in  AW+1  almost-empty threshold
- `pfull`  out  1  usedw >= pfull_thr and pfull_thr != 0
- `pempty`  out  1  usedw <= pempty_thr
- `err_clr`  in  1  clears `ovf` and `udf`
- `ovf`  out  1  sticky: write attempted while full and not accepted
- `udf`  out  1  sticky: read attempted while empty

## Operation
Storage and pointers:
- Storage is a DEPTH x DW register array.
- Write and read pointers are AW+1 bits wide and wrap naturally at 2·DEPTH; the array is indexed by the low AW bits.
- `usedw` is a registered counter, not derived from the pointers.

Write and read acceptance (evaluated each cycle, after flush):
- Write is accepted when `wr` and (not `full`, or `rd` is accepted in the same cycle).
- Read is accepted when `rd` and not `empty`.
- Count update: +1 for an accepted write only, −1 for an accepted read only, unchanged when both or neither are accepted.

Boundary cases:
- Full with `wr` and `rd` together: both are accepted, `usedw` stays at DEPTH, `ovf` is not set.
- Full with `wr` alone: the write is dropped and `ovf` is set.
- Empty with `rd` (with or without `wr`): the read is ignored and `udf` is set. A simultaneous write is still accepted, so `usedw` becomes 1.

Flush (highest priority):
- Pointers and `usedw` go to 0.
- `ovf` and `udf` are cleared.
- `wr` and `rd` in the same cycle are ignored and set no flags.
- The `dout` register is not cleared when FWFT=0.

Sticky flags:
- `err_clr` clears `ovf` and `udf`.
- If a new error occurs in the same cycle as `err_clr`, the set wins.

Read modes:
- FWFT=0: on an accepted read, the `dout` register loads the entry at the read pointer. `dout` holds otherwise.
- FWFT=1: `dout` = mem[read pointer] combinationally; it is valid whenever `empty` = 0, and `rd` pops the entry.

Output derivation:
- `full`, `empty`, `pfull` and `pempty` are combinational decodes of the registered `usedw` and the threshold inputs. They are glitch-free relative to `clk`.
- Threshold inputs may change at any time; the flags follow in the same cycle.

## Timing
Reset values:
- `usedw` = 0, `empty` = 1, `full` = 0.
- `ovf` = `udf` = 0.
- `dout` = 0.
- `pfull` = 0 unless the threshold condition already holds; `pempty` = 1.

Latencies:
- Write to flags: `usedw`, `empty` and `full` update in the cycle after the `wr` edge.
- FWFT=1: `dout` is valid in the cycle after the first write into an empty FIFO.
- FWFT=0: `dout` is valid in the cycle after the `rd` edge.
- Throughput: one write and one read per cycle sustained.
- Flush: effective at the next edge; `empty` = 1 in the following cycle.

Reset mid-operation:
- Asserting `rstn` low immediately forces all of the above reset values.
- Array contents need not be reset.

## Test plan
- Reset, then write 16 words 0x01..0x10 (DW=8, DEPTH=16, FWFT=0) -> `usedw` counts 1..16, `full` = 1 after the 16th. Then 16 reads return 0x01..0x10, each one cycle after its `rd`; `empty` = 1 at the end; `ovf` = `udf` = 0.
- With the FIFO full, pulse `wr` alone with 0xAA -> `ovf` = 1, `usedw` = 16. Then pulse `wr` and `rd` together with 0xBB -> `usedw` = 16, 0xBB is read last. Then `err_clr` -> `ovf` = 0.
- FWFT=1 with the FIFO empty: `rd` with `wr`=0x5A -> `udf` = 1, `usedw` = 1, and `dout` = 0x5A with `empty` = 0 in the next cycle.
- `pfull_thr` = 12, `pempty_thr` = 3: fill 0->16 -> `pfull` asserts when `usedw` reaches 12 and `pempty` deasserts at 4. Then `pfull_thr` = 0 -> `pfull` = 0.
- Write 7 words, then `flush` with `wr` and `rd` high in the same cycle -> next cycle `usedw` = 0, `empty` = 1, no flags set. Next write of 0x33 reads back as 0x33.
- 1000 cycles of random `wr`/`rd`/`flush` with pointer wrap (DEPTH=4, DW=10) against a scoreboard model -> data order, `usedw` and flags match exactly. Then assert `rstn` low mid-stream -> all outputs return to their reset values immediately.
